// File: rtl/i2c_slave_ctrl.sv
// Bit-level I2C slave sequencer: conditions SCL/SDA, detects START/STOP and drives the shift-register strobes.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample stability filter after each synchroniser.
module i2c_slave_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       comp_match,
    input  logic       read,
    input  logic [7:0] dr_data,
    output logic       shift_load_en,
    output logic       shift_en,
    output logic       ack_cycle,
    output logic       dack_cycle,
    output logic       sda_drive_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addr_hit,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, ADDR = 3'd1, ADDR_ACK = 3'd2, RX = 3'd3,
        RX_ACK = 3'd4, TX = 3'd5, TX_ACK = 3'd6, WAIT_STOP = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_lvl, sda_lvl, scl_hist_q, sda_hist_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_lvl;
            sda_hist_q <= sda_lvl;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_win_q, sda_win_q;
    logic       scl_raw, sda_raw;
    assign scl_raw = scl_sync_q[SYNC_STAGES-1];
    assign sda_raw = sda_sync_q[SYNC_STAGES-1];

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            scl_win_q <= '1;
            sda_win_q <= '1;
        end else begin
            scl_win_q <= {scl_win_q[0], scl_raw};
            sda_win_q <= {sda_win_q[0], sda_raw};
        end
    end

    // The history flop doubles as the filter's held level: a new level needs three equal samples.
    assign scl_lvl = (scl_raw == scl_win_q[0] && scl_raw == scl_win_q[1]) ? scl_raw : scl_hist_q;
    assign sda_lvl = (sda_raw == sda_win_q[0] && sda_raw == sda_win_q[1]) ? sda_raw : sda_hist_q;
`else
    assign scl_lvl = scl_sync_q[SYNC_STAGES-1];
    assign sda_lvl = sda_sync_q[SYNC_STAGES-1];
`endif

    assign scl_rise  =  scl_lvl & ~scl_hist_q;
    assign scl_fall  = ~scl_lvl &  scl_hist_q;
    assign start_det =  scl_lvl &  scl_hist_q &  sda_hist_q & ~sda_lvl;
    assign stop_det  =  scl_lvl &  scl_hist_q & ~sda_hist_q &  sda_lvl;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       bit8_q, bit8_d, ack_smp_q, ack_smp_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       load_q, load_d, shift_q, shift_d, ack_q, ack_d, dack_q, dack_d;
    logic       drv_q, drv_d, rxv_q, rxv_d, txr_q, txr_d, hit_q, hit_d, busy_q, busy_d;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit8_q    <= 1'b0;
            ack_smp_q <= 1'b1;
            rx_data_q <= '0;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
            ack_q     <= 1'b0;
            dack_q    <= 1'b0;
            drv_q     <= 1'b0;
            rxv_q     <= 1'b0;
            txr_q     <= 1'b0;
            hit_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit8_q    <= bit8_d;
            ack_smp_q <= ack_smp_d;
            rx_data_q <= rx_data_d;
            load_q    <= load_d;
            shift_q   <= shift_d;
            ack_q     <= ack_d;
            dack_q    <= dack_d;
            drv_q     <= drv_d;
            rxv_q     <= rxv_d;
            txr_q     <= txr_d;
            hit_q     <= hit_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det)       state_d = IDLE;
        else if (start_det) state_d = ADDR;
        else begin
            unique case (state_q)
                ADDR:     if (scl_fall && bit8_q) state_d = comp_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (scl_fall) state_d = read ? TX : RX;
                RX:       if (scl_fall && bit8_q) state_d = RX_ACK;
                RX_ACK:   if (scl_fall) state_d = RX;
                TX:       if (scl_fall && bit8_q) state_d = TX_ACK;
                TX_ACK:   if (scl_fall) state_d = ack_smp_q ? WAIT_STOP : TX;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        bit8_d    = bit8_q;
        ack_smp_d = ack_smp_q;
        rx_data_d = rx_data_q;
        load_d    = 1'b0;
        shift_d   = 1'b0;
        rxv_d     = 1'b0;
        txr_d     = 1'b0;
        hit_d     = hit_q;
        busy_d    = busy_q;

        // Any state change (including ACK-slot exit) or START restarts the byte.
        if (start_det || state_d != state_q) begin
            bit_cnt_d = '0;
            bit8_d    = 1'b0;
        end else if (scl_rise && (state_q == ADDR || state_q == RX || state_q == TX)) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) bit8_d = 1'b1;
        end

        if (stop_det) begin
            hit_d  = 1'b0;
            busy_d = 1'b0;
        end else if (start_det) begin
            hit_d  = 1'b0;
            busy_d = 1'b1;
        end else begin
            unique case (state_q)
                ADDR: begin
                    shift_d = scl_rise;
                    if (scl_fall && bit8_q && comp_match) hit_d = 1'b1;
                end
                ADDR_ACK: if (scl_fall && read) begin
                    load_d = 1'b1;
                    txr_d  = 1'b1;
                end
                RX: begin
                    shift_d = scl_rise;
                    if (scl_fall && bit8_q) begin
                        rx_data_d = dr_data;
                        rxv_d     = 1'b1;
                    end
                end
                // Bit 1 is already on the pad after the load, so only bits 2..8 need a shift.
                TX: shift_d = scl_fall && !bit8_q && (bit_cnt_q != 3'd0);
                TX_ACK: begin
                    if (scl_rise) ack_smp_d = sda_lvl;
                    if (scl_fall && !ack_smp_q) begin
                        load_d = 1'b1;
                        txr_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        ack_d  = (state_d == ADDR_ACK);
        dack_d = (state_d == RX_ACK);
        drv_d  = (state_d == ADDR_ACK) || (state_d == RX_ACK) || (state_d == TX);
    end

    assign shift_load_en = load_q;
    assign shift_en      = shift_q;
    assign ack_cycle     = ack_q;
    assign dack_cycle    = dack_q;
    assign sda_drive_en  = drv_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rxv_q;
    assign tx_req        = txr_q;
    assign addr_hit      = hit_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: behavioural I2C master, open-drain bus and shift-register model.
module tb_i2c_slave_ctrl;
    localparam int Q = 5;  // pclk cycles per quarter SCL period

    logic       pclk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
    logic [7:0] sr = 8'h00, tx_data = 8'h00;
    logic       sda_bus, sda_out_bit;
    logic       shift_load_en, shift_en, ack_cycle, dack_cycle, sda_drive_en;
    logic       rx_valid, tx_req, addr_hit, busy;
    logic [7:0] rx_data;
    int passes = 0, fails = 0, total = 0;
    int n_shift = 0, n_rxv = 0, n_txr = 0, n_drv = 0, n_both = 0;
    logic last_ack_cyc = 1'b0, last_dack_cyc = 1'b0, last_drv = 1'b0;

    i2c_slave_ctrl #(.SYNC_STAGES(2)) dut (
        .pclk(pclk), .rst(rst), .scl_in(m_scl), .sda_in(sda_bus),
        .comp_match(sr[7:1] == 7'h48), .read(sr[0]), .dr_data(sr),
        .shift_load_en(shift_load_en), .shift_en(shift_en), .ack_cycle(ack_cycle),
        .dack_cycle(dack_cycle), .sda_drive_en(sda_drive_en), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_req(tx_req), .addr_hit(addr_hit), .busy(busy)
    );

    always #5 pclk = ~pclk;

    assign sda_out_bit = (ack_cycle | dack_cycle) ? 1'b0 : sr[7];
    assign sda_bus     = m_sda & ~(sda_drive_en & ~sda_out_bit);

    always @(posedge pclk)
        if (shift_load_en) sr <= tx_data;
        else if (shift_en) sr <= {sr[6:0], sda_bus};

    always @(negedge pclk) begin
        if (shift_en)     n_shift <= n_shift + 1;
        if (rx_valid)     n_rxv   <= n_rxv + 1;
        if (tx_req)       n_txr   <= n_txr + 1;
        if (sda_drive_en) n_drv   <= n_drv + 1;
        if ((shift_en && shift_load_en) || (ack_cycle && dack_cycle)) n_both <= n_both + 1;
    end

    task automatic w(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_cond();
        m_sda = 1'b1; w(Q);
        m_scl = 1'b1; w(Q);
        m_sda = 1'b0; w(Q);
        m_scl = 1'b0; w(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; w(Q);
        m_scl = 1'b1; w(Q);
        m_sda = 1'b1; w(2*Q);
    endtask

    task automatic send_bit(input logic b, input logic g);
        m_sda = b;
        if (g) begin
            w(1); m_scl = 1'b1; w(2); m_scl = 1'b0; w(Q-3);
        end else w(Q);
        m_scl = 1'b1; w(2*Q);
        m_scl = 1'b0; w(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; w(Q);
        m_scl = 1'b1; w(Q);
        b = sda_bus;
        last_ack_cyc = ack_cycle; last_dack_cyc = dack_cycle; last_drv = sda_drive_en;
        w(Q);
        m_scl = 1'b0; w(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [7:0] gm, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], gm[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(ack_bit, 1'b0);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int s_sh, s_rx, s_tx, s_drv;

        w(3);
        chk("rst_outs", {shift_load_en, shift_en, ack_cycle, dack_cycle, sda_drive_en,
                         rx_valid, tx_req, addr_hit, busy}, 0);
        chk("rst_state", dut.state_q, 0);
        chk("rst_bitcnt", dut.bit_cnt_q, 0);
        chk("rst_rxdata", rx_data, 8'h00);
        rst = 1'b0; w(10);

        // write 8'hA5 to address 7'h48
        s_sh = n_shift; s_rx = n_rxv;
        start_cond();
        chk("wr_busy", busy, 1);
        chk("wr_state_addr", dut.state_q, 1);
        send_byte(8'h90, 8'h00, ack);
        chk("wr_addr_ack", ack, 0);
        chk("wr_ack_slot", {last_ack_cyc, last_dack_cyc, last_drv}, 3'b101);
        chk("wr_addr_hit", addr_hit, 1);
        send_byte(8'hA5, 8'h00, ack);
        chk("wr_data_ack", ack, 0);
        chk("wr_dack_slot", {last_ack_cyc, last_dack_cyc, last_drv}, 3'b011);
        chk("wr_rx_data", rx_data, 8'hA5);
        chk("wr_rx_valid", n_rxv - s_rx, 1);
        chk("wr_shift_cnt", n_shift - s_sh, 16);
        stop_cond();
        chk("wr_stop_hit", addr_hit, 0);
        chk("wr_stop_busy", busy, 0);
        chk("wr_stop_state", dut.state_q, 0);

        // address mismatch
        s_rx = n_rxv; s_tx = n_txr; s_drv = n_drv;
        start_cond();
        send_byte(8'h42, 8'h00, ack);
        chk("mm_nack", ack, 1);
        chk("mm_state", dut.state_q, 7);
        send_byte(8'h11, 8'h00, ack);
        chk("mm_state2", dut.state_q, 7);
        chk("mm_hit", addr_hit, 0);
        stop_cond();
        chk("mm_idle", dut.state_q, 0);
        chk("mm_drv", n_drv - s_drv, 0);
        chk("mm_rxv", n_rxv - s_rx, 0);
        chk("mm_txr", n_txr - s_tx, 0);

        // read two bytes, ACK then NACK
        tx_data = 8'hC3; s_tx = n_txr;
        start_cond();
        send_byte(8'h91, 8'h00, ack);
        chk("rd_addr_ack", ack, 0);
        tx_data = 8'h5A; s_sh = n_shift;
        recv_byte(d, 1'b0);
        chk("rd_byte1", d, 8'hC3);
        chk("rd_shift1", n_shift - s_sh, 7);
        s_sh = n_shift;
        recv_byte(d, 1'b1);
        chk("rd_byte2", d, 8'h5A);
        chk("rd_shift2", n_shift - s_sh, 7);
        chk("rd_txreq", n_txr - s_tx, 2);
        chk("rd_state_wait", dut.state_q, 7);
        chk("rd_release", sda_drive_en, 0);
        stop_cond();
        chk("rd_idle", dut.state_q, 0);

        // repeated START during bit 4 of a write byte
        s_rx = n_rxv;
        start_cond();
        send_byte(8'h90, 8'h00, ack);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk("rs_cnt_pre", dut.bit_cnt_q, 4);
        start_cond();
        chk("rs_state", dut.state_q, 1);
        chk("rs_bitcnt", dut.bit_cnt_q, 0);
        chk("rs_hit", addr_hit, 0);
        chk("rs_busy", busy, 1);
        chk("rs_rxv", n_rxv - s_rx, 0);
        chk("rs_rxdata", rx_data, 8'hA5);
        send_byte(8'h90, 8'h00, ack);
        send_byte(8'h3C, 8'h00, ack);
        stop_cond();
        chk("rs_rxdata2", rx_data, 8'h3C);
        chk("rs_rxv2", n_rxv - s_rx, 1);

        // asynchronous reset during TX
        tx_data = 8'hF0;
        start_cond();
        send_byte(8'h91, 8'h00, ack);
        recv_bit(b); recv_bit(b); recv_bit(b);
        chk("rt_tx_state", dut.state_q, 5);
        chk("rt_tx_drv", sda_drive_en, 1);
        #3 rst = 1'b1;
        #1;
        chk("rt_async_outs", {shift_load_en, shift_en, ack_cycle, dack_cycle, sda_drive_en,
                              rx_valid, tx_req, addr_hit, busy}, 0);
        chk("rt_async_state", dut.state_q, 0);
        chk("rt_async_rxdata", rx_data, 8'h00);
        w(2);
        m_scl = 1'b1; m_sda = 1'b1; w(4);
        rst = 1'b0; w(10);
        start_cond();
        send_byte(8'h90, 8'h00, ack);
        chk("rt_addr_ack", ack, 0);
        send_byte(8'h77, 8'h00, ack);
        stop_cond();
        chk("rt_rxdata", rx_data, 8'h77);
        chk("rt_busy", busy, 0);

`ifdef I2C_GLITCH_FILTER_EN
        start_cond();
        send_byte(8'h90, 8'h00, ack);
        s_sh = n_shift;
        send_byte(8'h96, 8'h10, ack);
        chk("gf_shift", n_shift - s_sh, 8);
        chk("gf_rxdata", rx_data, 8'h96);
        stop_cond();
`endif

        chk("no_overlap", n_both, 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
